// File: rtl/tpu_package.sv
// Shared types and sizing for the accumulator drain path.
// Holds array geometry, FIFO depth, the drain FSM states and helpers.
package tpu_package;

  localparam int MUL_SIZE   = 32;
  localparam int ACC_W      = 32;
  localparam int ACC_RD_LAT = 1;
  localparam int FIFO_DEPTH = 4;

  localparam int ADDR_W     = 10;
  localparam int ROW_W      = MUL_SIZE * 8;
  localparam int ACC_ROW_W  = MUL_SIZE * ACC_W;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    FINISH
  } drain_state_e;

  localparam logic signed [ACC_W:0] SAT_MAX = 127;
  localparam logic signed [ACC_W:0] SAT_MIN = -128;

  // Rows to drain. The product is cut to 15 bits before the
  // divide-by-32 so the bound matches the accumulator controller.
  function automatic logic [ADDR_W-1:0] row_count(
    input logic [7:0] v,
    input logic [7:0] u
  );
    return ADDR_W'(
      15'({8'd0, v} * {8'd0, u}) >> 5
    );
  endfunction

  // Optional ReLU followed by clamp into the int8 range.
  function automatic logic [7:0] sat8(
    input logic signed [ACC_W:0] x,
    input logic                  relu
  );
    if (relu && x[ACC_W])
      return 8'h00;
    if (x > SAT_MAX)
      return 8'h7f;
    if (x < SAT_MIN)
      return 8'h80;
    return x[7:0];
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with registered storage and count.
// Ports: clk_i/rst_i, push_i+din_i, pop_i, dout_o (head),
//        count_o, full_o, empty_o. Push while full is legal
//        only together with a pop; the count is then unchanged.
module drain_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 din_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 dout_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic do_pop;
  logic do_push;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop)
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/accum_drain_unit.sv
// Drains accumulator rows, requantises each lane to int8 and
// writes the packed rows into the unified buffer.
// Ports: clk_i/rst_i; start_i with V/U dims, shift, relu and
//        UB base sampled on accepted start; acc_rd_o/acc_addr_o
//        and acc_data_i (ACC_RD_LAT latency) toward the
//        accumulator; ub_wr_valid_o/ready_i/addr_o/data_o toward
//        the unified buffer; busy_o and a one-cycle done_o.
module accum_drain_unit
  import tpu_package::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [7:0]           V_dim_i,
  input  logic [7:0]           U_dim_i,
  input  logic [4:0]           shift_i,
  input  logic                 relu_en_i,
  input  logic [ADDR_W-1:0]    ub_base_i,
  output logic                 acc_rd_o,
  output logic [ADDR_W-1:0]    acc_addr_o,
  input  logic [ACC_ROW_W-1:0] acc_data_i,
  output logic                 ub_wr_valid_o,
  input  logic                 ub_wr_ready_i,
  output logic [ADDR_W-1:0]    ub_wr_addr_o,
  output logic [ROW_W-1:0]     ub_wr_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic signed [ACC_W:0] RND_ONE = 1;

  drain_state_e state_q, state_d;

  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [4:0]        shift_q, shift_d;
  logic              relu_q, relu_d;
  logic              done_q, done_d;

  // One bit per outstanding read; the top bit marks the cycle
  // in which that read's data is on acc_data_i.
  logic [ACC_RD_LAT-1:0] pipe_q, pipe_d;

  logic [ADDR_W-1:0]     n_start;
  logic                  start_ok;
  logic                  rd_en;
  logic                  last_rd;
  logic                  wr_fire;
  logic                  push;
  logic                  flush_done;
  logic [7:0]            occ;

  logic [ROW_W-1:0]      q_row;
  logic [ROW_W-1:0]      fifo_dout;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign n_start  = row_count(V_dim_i, U_dim_i);
  assign start_ok = start_i && (state_q == IDLE);

  // Reads in flight plus rows already buffered. A read is only
  // issued when its data is guaranteed a FIFO slot on return.
  always_comb begin
    occ = 8'(fifo_count);
    for (int i = 0; i < ACC_RD_LAT; i++)
      occ = occ + 8'(pipe_q[i]);
  end

  assign rd_en = (state_q == DRAIN)
              && (occ < 8'(FIFO_DEPTH))
              && !fifo_full;

  assign last_rd = rd_en && (rd_cnt_q == n_q - 10'd1);

  assign push    = pipe_q[ACC_RD_LAT-1];
  assign wr_fire = !fifo_empty && ub_wr_ready_i;

  assign flush_done = fifo_empty
                   && (pipe_q == '0)
                   && (wr_cnt_q == n_q);

  if (ACC_RD_LAT == 1) begin : g_pipe1
    assign pipe_d = rd_en;
  end else begin : g_pipen
    assign pipe_d = {pipe_q[ACC_RD_LAT-2:0], rd_en};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_i)
          state_d = (n_start == '0) ? FINISH : DRAIN;
      end
      DRAIN: begin
        if (last_rd)
          state_d = FLUSH;
      end
      FLUSH: begin
        if (flush_done)
          state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    n_d         = n_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    base_d      = base_q;
    last_addr_d = last_addr_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    done_d      = (state_q == FINISH);
    if (start_ok) begin
      n_d      = n_start;
      rd_cnt_d = '0;
      wr_cnt_d = '0;
      base_d   = ub_base_i;
      shift_d  = shift_i;
      relu_d   = relu_en_i;
    end
    if (rd_en) begin
      rd_cnt_d    = rd_cnt_q + 10'd1;
      last_addr_d = rd_cnt_q;
    end
    if (wr_fire)
      wr_cnt_d = wr_cnt_q + 10'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      n_q         <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      base_q      <= '0;
      last_addr_q <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      done_q      <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      base_q      <= base_d;
      last_addr_q <= last_addr_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      done_q      <= done_d;
      pipe_q      <= pipe_d;
    end
  end

  // Per-lane requantisation: round-half-up, arithmetic shift,
  // optional ReLU, int8 saturation. One extra bit of headroom
  // keeps the rounding add from overflowing.
  for (genvar l = 0; l < MUL_SIZE; l++) begin : g_lane
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shd;

    always_comb begin
      ext = {acc_data_i[l*ACC_W + ACC_W - 1],
             acc_data_i[l*ACC_W +: ACC_W]};
      rnd = ext;
      if (shift_q != '0)
        rnd = ext + (RND_ONE <<< (shift_q - 5'd1));
      shd = rnd >>> shift_q;
    end

    assign q_row[l*8 +: 8] = sat8(shd, relu_q);
  end

  drain_fifo #(
    .W     (ROW_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .din_i   (q_row),
    .pop_i   (wr_fire),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign acc_rd_o      = rd_en;
  assign acc_addr_o    = rd_en ? rd_cnt_q : last_addr_q;
  assign ub_wr_valid_o = !fifo_empty;
  assign ub_wr_data_o  = fifo_dout;
  assign ub_wr_addr_o  = base_q + wr_cnt_q;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule
